sine_step_ctrl: RTL and testbench



---
 rtl/sine_step_ctrl_if.sv | 41 ++++
 rtl/sine_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_sine_step_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sine_step_ctrl_if.sv
// Flag/direction bundle between the sine step controller and the sine
// datapath plus its downstream consumers (DAC switch, period monitor).
// The master side is the controller; the slave side is the datapath and
// whatever observes the strobes and status flags.
interface sine_step_ctrl_if #(
   parameter int CYC_W = 16
);
   logic             max;
   logic             zero;
   logic             dir;
   logic             polarity;
   logic             peak_pulse;
   logic             zc_pulse;
   logic [CYC_W-1:0] period_cnt;
   logic             seq_err;
   logic             wdog_err;

   modport master (
      input  max,
      input  zero,
      output dir,
      output polarity,
      output peak_pulse,
      output zc_pulse,
      output period_cnt,
      output seq_err,
      output wdog_err
   );

   modport slave (
      output max,
      output zero,
      input  dir,
      input  polarity,
      input  peak_pulse,
      input  zc_pulse,
      input  period_cnt,
      input  seq_err,
      input  wdog_err
   );
endinterface

// File: rtl/sine_step_ctrl.sv
// Direction controller for the 7-bit sine phase register.
// It turns the sweep at 126 and at 1, so the register never reaches 127 or
// wraps through 0. It also tracks the half-wave polarity for the DAC, emits
// peak and zero-crossing strobes, counts full periods and flags inconsistent
// flag sequences.
// Optional build macro: SINE_STEP_CTRL_WDOG_EN adds a turn-to-turn watchdog.
// Without it, wdog_err is tied low.
module sine_step_ctrl #(
   parameter int          CYC_W      = 16,
   parameter int unsigned WDOG_LIMIT = 130
) (
   input logic              clk,
   input logic              rst,
   sine_step_ctrl_if.master bus
);

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             dir_c;
   logic             peak_turn;
   logic             zc_turn;
   logic             err_event;
   logic             peak_seen;
   logic             polarity;
   logic             peak_pulse;
   logic             zc_pulse;
   logic [CYC_W-1:0] period_cnt;
   logic             seq_err;

   // Sweep direction register; reset always restarts the sweep upward
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= UP;
      end else begin
         state <= next_state;
      end
   end

   // Mealy direction plus turn and error decode, so dir flips in the same cycle the flag appears
   always_comb begin
      next_state = state;
      dir_c      = 1'b0;
      peak_turn  = 1'b0;
      zc_turn    = 1'b0;
      err_event  = 1'b0;
      case (state)
         UP: begin
            dir_c = bus.max;
            if (bus.max) begin
               next_state = DOWN;
               peak_turn  = 1'b1;
            end
            if (bus.zero && peak_seen) begin
               err_event = 1'b1;
            end
         end
         DOWN: begin
            dir_c = ~bus.zero;
            if (bus.zero) begin
               next_state = UP;
               zc_turn    = 1'b1;
            end
            if (bus.max) begin
               err_event = 1'b1;
            end
         end
      endcase
      if (bus.max && bus.zero) begin
         err_event = 1'b1;
      end
   end

   // Registered strobes, polarity, period count and sticky sequence error
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_pulse <= 1'b0;
         zc_pulse   <= 1'b0;
         polarity   <= 1'b0;
         period_cnt <= '0;
         peak_seen  <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         peak_pulse <= peak_turn;
         zc_pulse   <= zc_turn;
         if (zc_turn) begin
            polarity <= ~polarity;
            if (polarity) begin
               period_cnt <= period_cnt + 1'b1;
            end
         end
         if (peak_turn) begin
            peak_seen <= 1'b1;
         end
         if (err_event) begin
            seq_err <= 1'b1;
         end
      end
   end

   assign bus.dir        = dir_c;
   assign bus.polarity   = polarity;
   assign bus.peak_pulse = peak_pulse;
   assign bus.zc_pulse   = zc_pulse;
   assign bus.period_cnt = period_cnt;
   assign bus.seq_err    = seq_err;

`ifdef SINE_STEP_CTRL_WDOG_EN
   logic [7:0] wdog_cnt;
   logic [7:0] wdog_cnt_next;
   logic       wdog_err;

   // Next watchdog count: cleared by a turn, otherwise counts up and saturates at all-ones
   always_comb begin
      wdog_cnt_next = wdog_cnt;
      if (peak_turn || zc_turn) begin
         wdog_cnt_next = 8'd0;
      end else if (wdog_cnt != 8'hFF) begin
         wdog_cnt_next = wdog_cnt + 8'd1;
      end
   end

   // Watchdog counter and sticky flag, raised in the cycle the count reaches the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= 8'd0;
         wdog_err <= 1'b0;
      end else begin
         wdog_cnt <= wdog_cnt_next;
         if (32'(wdog_cnt_next) >= WDOG_LIMIT) begin
            wdog_err <= 1'b1;
         end
      end
   end

   assign bus.wdog_err = wdog_err;
`else
   assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_sine_step_ctrl.sv
// Closed-loop bench for sine_step_ctrl: a behavioural 7-bit phase register
// follows dir and feeds back the max/zero flags. A second instance with a
// 2-bit period counter checks the counter wrap. All expected values are
// hand-computed from the step timing (r(0) = 0, the first max is at t = 126,
// and the first zero turn is at t = 251).
module tb_sine_step_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic open_loop = 1'b0;
   logic force_max = 1'b0;
   logic [6:0] r_a;
   logic [6:0] r_b;
   int t = 0;
   int check_count = 0;
   int pass_count = 0;

`ifdef SINE_STEP_CTRL_WDOG_EN
   localparam logic WDOG_EXP = 1'b1;
`else
   localparam logic WDOG_EXP = 1'b0;
`endif

   sine_step_ctrl_if #(.CYC_W(16)) bus_a ();
   sine_step_ctrl_if #(.CYC_W(2))  bus_b ();

   sine_step_ctrl #(.CYC_W(16), .WDOG_LIMIT(130)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   sine_step_ctrl #(.CYC_W(2), .WDOG_LIMIT(130)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   assign bus_a.max  = !open_loop && ((r_a == 7'd126) || force_max);
   assign bus_a.zero = !open_loop && (r_a == 7'd1);
   assign bus_b.max  = !open_loop && (r_b == 7'd126);
   assign bus_b.zero = !open_loop && (r_b == 7'd1);

   // Behavioural datapath phase registers, stepping +1 or -1 according to dir
   always @(posedge clk) begin
      if (rst) begin
         r_a <= 7'd0;
         r_b <= 7'd0;
      end else begin
         r_a <= bus_a.dir ? r_a - 7'd1 : r_a + 7'd1;
         r_b <= bus_b.dir ? r_b - 7'd1 : r_b + 7'd1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", tag, t, observed, expected);
      end else begin
         pass_count++;
      end
   endtask

   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t = 0;
   endtask

   // Directed scenario sequence
   initial begin
      int dir_bad;
      int pk_bad;
      int zc_bad;
      int range_bad;
      int err_bad;
      int hold_bad;
      logic exp_dir;

      // Closed-loop run: startup, turns, polarity, period counts
      applyReset();
      checkOutput("rst_dir", 32'(bus_a.dir), 32'd0);
      checkOutput("rst_polarity", 32'(bus_a.polarity), 32'd0);
      checkOutput("rst_peak", 32'(bus_a.peak_pulse), 32'd0);
      checkOutput("rst_zc", 32'(bus_a.zc_pulse), 32'd0);
      checkOutput("rst_period", 32'(bus_a.period_cnt), 32'd0);
      checkOutput("rst_seq_err", 32'(bus_a.seq_err), 32'd0);
      checkOutput("rst_wdog_err", 32'(bus_a.wdog_err), 32'd0);

      dir_bad = 0; pk_bad = 0; zc_bad = 0; range_bad = 0; err_bad = 0;
      while (t <= 2010) begin
         if (t <= 260) begin
            exp_dir = (t >= 126) && (t <= 250);
            if (bus_a.dir !== exp_dir) dir_bad++;
            if (bus_a.peak_pulse !== (t == 127)) pk_bad++;
            if (bus_a.zc_pulse !== (t == 252)) zc_bad++;
         end
         if (r_a > 7'd126 || r_b > 7'd126) range_bad++;
         if (bus_a.seq_err || bus_a.wdog_err || bus_b.seq_err || bus_b.wdog_err) err_bad++;
         case (t)
            125:  checkOutput("dir_before_max", 32'(bus_a.dir), 32'd0);
            126:  checkOutput("dir_at_max", 32'(bus_a.dir), 32'd1);
            127:  checkOutput("peak_pulse", 32'(bus_a.peak_pulse), 32'd1);
            251:  checkOutput("polarity_pre_zc", 32'(bus_a.polarity), 32'd0);
            252: begin
               checkOutput("polarity_post_zc", 32'(bus_a.polarity), 32'd1);
               checkOutput("zc_pulse", 32'(bus_a.zc_pulse), 32'd1);
            end
            501:  checkOutput("period_501", 32'(bus_a.period_cnt), 32'd0);
            502: begin
               checkOutput("period_502", 32'(bus_a.period_cnt), 32'd1);
               checkOutput("wrap_502", 32'(bus_b.period_cnt), 32'd1);
            end
            1002: checkOutput("wrap_1002", 32'(bus_b.period_cnt), 32'd2);
            1502: checkOutput("wrap_1502", 32'(bus_b.period_cnt), 32'd3);
            1751: checkOutput("period_1751", 32'(bus_a.period_cnt), 32'd3);
            2001: checkOutput("wrap_2001", 32'(bus_b.period_cnt), 32'd3);
            2002: checkOutput("wrap_2002", 32'(bus_b.period_cnt), 32'd0);
            default: ;
         endcase
         applyStimulus(1);
      end
      checkOutput("dir_profile_bad_cycles", 32'(dir_bad), 32'd0);
      checkOutput("peak_profile_bad_cycles", 32'(pk_bad), 32'd0);
      checkOutput("zc_profile_bad_cycles", 32'(zc_bad), 32'd0);
      checkOutput("range_bad_cycles", 32'(range_bad), 32'd0);
      checkOutput("error_flag_cycles", 32'(err_bad), 32'd0);

      // Forced max while sweeping down, then reset in mid-operation
      applyReset();
      applyStimulus(200);
      force_max = 1'b1;
      #1;
      checkOutput("forced_max_dir", 32'(bus_a.dir), 32'd1);
      checkOutput("seq_err_before", 32'(bus_a.seq_err), 32'd0);
      applyStimulus(1);
      force_max = 1'b0;
      checkOutput("seq_err_set", 32'(bus_a.seq_err), 32'd1);
      hold_bad = 0;
      while (t < 300) begin
         applyStimulus(1);
         if (bus_a.seq_err !== 1'b1) hold_bad++;
      end
      checkOutput("seq_err_hold_bad_cycles", 32'(hold_bad), 32'd0);
      checkOutput("polarity_before_rst", 32'(bus_a.polarity), 32'd1);
      applyReset();
      checkOutput("mid_rst_dir", 32'(bus_a.dir), 32'd0);
      checkOutput("mid_rst_polarity", 32'(bus_a.polarity), 32'd0);
      checkOutput("mid_rst_period", 32'(bus_a.period_cnt), 32'd0);
      checkOutput("mid_rst_seq_err", 32'(bus_a.seq_err), 32'd0);
      checkOutput("mid_rst_wdog_err", 32'(bus_a.wdog_err), 32'd0);
      applyStimulus(125);
      checkOutput("rerun_dir_125", 32'(bus_a.dir), 32'd0);
      applyStimulus(1);
      checkOutput("rerun_dir_126", 32'(bus_a.dir), 32'd1);
      applyStimulus(1);
      checkOutput("rerun_peak_127", 32'(bus_a.peak_pulse), 32'd1);

      // Open loop: both flags held low, so only the watchdog can react
      open_loop = 1'b1;
      applyReset();
      applyStimulus(129);
      checkOutput("wdog_129", 32'(bus_a.wdog_err), 32'd0);
      applyStimulus(1);
      checkOutput("wdog_130", 32'(bus_a.wdog_err), 32'(WDOG_EXP));
      applyStimulus(10);
      checkOutput("wdog_140", 32'(bus_a.wdog_err), 32'(WDOG_EXP));
      checkOutput("open_loop_dir", 32'(bus_a.dir), 32'd0);
      checkOutput("open_loop_seq_err", 32'(bus_a.seq_err), 32'd0);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
